// File: rtl/ws_sequencer.sv
// Weight-stationary tile sequencer: walks one tile through weight load, kernel
// load, skew wait, activation load, execute and psum drain, emitting a registered core instruction word.
module ws_sequencer #(
  parameter int row = 8,
  parameter int col = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        acc_en,
  input  logic [10:0] w_base,
  input  logic [10:0] x_base,
  input  logic [10:0] p_base,
  input  logic [10:0] n_act,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, WLOAD, KLOAD, KWAIT, ALOAD, EXEC, DRAIN, DONE} state_t;

  localparam logic [11:0] COL_N  = 12'(col);
  localparam logic [11:0] WAIT_N = 12'(row + col);

  state_t      state, state_n;
  logic [11:0] k, k_n;
  logic [10:0] j, j_n;
  logic        cap;
  logic [34:0] inst_n;

  logic        mode_q, acc_q;
  logic [10:0] w_q, x_q, p_q, n_q;
  logic [11:0] n_ext;

  assign n_ext = {1'b0, n_q};

  always_comb begin
    state_n = state;
    k_n     = k;
    j_n     = j;
    cap     = 1'b0;
    inst_n  = {mode_q, 1'b0, 2'b11, 11'd0, 2'b11, 11'd0, 7'd0};
    case (state)
      IDLE: begin
        // registered busy also covers the cycle right after DONE
        if (start && !busy) begin
          cap     = 1'b1;
          state_n = WLOAD;
          k_n     = '0;
          j_n     = '0;
        end
      end
      WLOAD: begin
        if (k < COL_N) begin
          inst_n[19]   = 1'b0;
          inst_n[17:7] = w_q + k[10:0];
        end
        if (k != 12'd0) inst_n[2] = 1'b1;
        if (k == COL_N) begin
          state_n = KLOAD;
          k_n     = '0;
        end else k_n = k + 12'd1;
      end
      KLOAD: begin
        inst_n[3] = 1'b1;
        inst_n[0] = 1'b1;
        if (k == COL_N - 12'd1) begin
          state_n = KWAIT;
          k_n     = '0;
        end else k_n = k + 12'd1;
      end
      KWAIT: begin
        if (k == WAIT_N - 12'd1) begin
          state_n = (n_q == 11'd0) ? DONE : ALOAD;
          k_n     = '0;
        end else k_n = k + 12'd1;
      end
      ALOAD: begin
        if (k < n_ext) begin
          inst_n[19]   = 1'b0;
          inst_n[17:7] = x_q + k[10:0];
        end
        if (k != 12'd0) inst_n[2] = 1'b1;
        if (k == n_ext) begin
          state_n = EXEC;
          k_n     = '0;
        end else k_n = k + 12'd1;
      end
      EXEC: begin
        inst_n[3] = 1'b1;
        inst_n[1] = 1'b1;
        if (k == n_ext - 12'd1) begin
          state_n = DRAIN;
          k_n     = '0;
          j_n     = '0;
        end else k_n = k + 12'd1;
      end
      DRAIN: begin
        if (ofifo_valid) begin
          inst_n[6]     = 1'b1;
          inst_n[32]    = 1'b0;
          inst_n[31]    = 1'b0;
          inst_n[30:20] = p_q + j;
          inst_n[33]    = acc_q;
          j_n           = j + 11'd1;
          if (j == n_q - 11'd1) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      k      <= '0;
      j      <= '0;
      mode_q <= 1'b0;
      acc_q  <= 1'b0;
      w_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      n_q    <= '0;
      inst   <= {1'b0, 1'b0, 2'b11, 11'd0, 2'b11, 11'd0, 7'd0};
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      j     <= j_n;
      if (cap) begin
        mode_q <= mode;
        acc_q  <= acc_en;
        w_q    <= w_base;
        x_q    <= x_base;
        p_q    <= p_base;
        n_q    <= n_act;
      end
      inst <= inst_n;
      busy <= (state != IDLE);
      done <= (state == DONE);
    end
  end

endmodule
